// File: rtl/mem_test_seq.sv
// -----------------------------------------------------------------------------
// mem_test_seq
//
// Write-then-readback sequencer for a 64-bit data memory with separate read and
// write address ports, a write strobe and a synchronous write. A run writes
// NUM_WORDS pattern words starting at BASE_ADDR with a fixed byte STRIDE, reads
// them back, and compares every returned word with the value that was written.
// The run reports pass/fail, a saturating mismatch count and the address of
// the first mismatch. Serves as a bench stimulus engine and as an on-chip
// memory self-test ahead of the pipeline.
//
// Ports
//   clk            system clock, rising edge
//   nrst           asynchronous reset, active low (aborts any run)
//   start          one-cycle run request, only honoured in IDLE
//   mode           pattern: 0 incr, 1 addr-as-data, 2 walking one, 3 inverted incr
//   raddress       memory read address (holds its last value after READ)
//   waddress       memory write address
//   datain         memory write data
//   wr             memory write enable
//   dataout        memory read data, valid RD_LATENCY cycles after raddress
//   busy           run in progress (WRITE, READ, DRAIN)
//   done           one-cycle pulse in the final cycle of a run
//   pass           result of the last run, held until the next accepted start
//   err_count      mismatches in the last run, saturating
//   first_err_addr address of the first mismatch, 0 if none
// -----------------------------------------------------------------------------
module mem_test_seq #(
  parameter int unsigned     DATA_W     = 64,
  parameter int unsigned     ADDR_W     = 64,
  parameter longint unsigned BASE_ADDR  = 0,
  parameter int unsigned     NUM_WORDS  = 8,
  parameter longint unsigned STRIDE     = 8,
  parameter int unsigned     RD_LATENCY = 1,
  parameter int unsigned     ERR_W      = 16
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic [ADDR_W-1:0] raddress,
  output logic [ADDR_W-1:0] waddress,
  output logic [DATA_W-1:0] datain,
  output logic              wr,
  input  logic [DATA_W-1:0] dataout,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    PAT_INCR,
    PAT_ADDR,
    PAT_WALK,
    PAT_INV
  } pattern_e;

  localparam int unsigned LAT       = RD_LATENCY;
  localparam int unsigned CNT_W     = $clog2(NUM_WORDS + RD_LATENCY + 1);
  localparam int unsigned EXP_BITS  = LAT * DATA_W;
  localparam int unsigned ADR_BITS  = LAT * ADDR_W;

  localparam logic [ADDR_W-1:0] BASE_A     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] STRIDE_A   = ADDR_W'(STRIDE);
  localparam logic [DATA_W-1:0] STRIDE_D   = DATA_W'(STRIDE);
  localparam logic [ERR_W-1:0]  ERR_MAX    = '1;
  localparam logic [CNT_W-1:0]  LAST_WORD  = CNT_W'(NUM_WORDS - 1);
  localparam logic [CNT_W-1:0]  LAST_DRAIN = CNT_W'(RD_LATENCY - 1);

  state_e            state_q, state_d;
  pattern_e          mode_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;       // BASE + i*STRIDE for the current word
  logic [DATA_W-1:0] offs_q;       // i*STRIDE, truncated to the data width
  logic [DATA_W-1:0] walk_q;       // 1 << (i mod DATA_W)
  logic [ADDR_W-1:0] raddr_hold_q;
  logic [DATA_W-1:0] pattern;

  logic              accept;
  logic              seq_restart;
  logic              issue;

  // Compare pipeline: entry 0 is the newest read, entry LAT-1 lines up with
  // the dataout it is checked against.
  logic [LAT-1:0]                 vld_q;
  logic [LAT-1:0][DATA_W-1:0]     exp_q;
  logic [LAT-1:0][ADDR_W-1:0]     adr_q;

  logic              cmp_vld;
  logic [DATA_W-1:0] cmp_exp;
  logic [ADDR_W-1:0] cmp_addr;
  logic              mismatch;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [ADDR_W-1:0] first_q;
  logic              pass_q;

  assign accept = (state_q == S_IDLE) && start;
  assign issue  = (state_q == S_READ);

  // ---------------------------------------------------------------------------
  // Sequencing FSM
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every register in
  // this block samples the pre-edge values; blocking here would let later
  // statements see the new state in the same edge.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: state_d gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start)                state_d = S_WRITE;
      S_WRITE: if (cnt_q == LAST_WORD)   state_d = S_READ;
      S_READ:  if (cnt_q == LAST_WORD)   state_d = S_DRAIN;
      S_DRAIN: if (cnt_q == LAST_DRAIN)  state_d = S_DONE;
      S_DONE:                            state_d = S_IDLE;
      default:                           state_d = S_IDLE;
    endcase
  end

  // Per-phase counter: restarts at 0 on every state change.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q <= '0;
    end else if (state_q == S_IDLE || state_d != state_q) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Address / pattern generator. Incremental so no multiplier is needed; it is
  // rewound at the start of WRITE and again at the start of READ so the read
  // phase regenerates exactly the written sequence.
  // ---------------------------------------------------------------------------
  assign seq_restart = accept || (state_q == S_WRITE && state_d == S_READ);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      mode_q       <= PAT_INCR;
      addr_q       <= '0;
      offs_q       <= '0;
      walk_q       <= '0;
      raddr_hold_q <= '0;
    end else begin
      if (accept) mode_q <= pattern_e'(mode);
      if (seq_restart) begin
        addr_q <= BASE_A;
        offs_q <= '0;
        walk_q <= DATA_W'(1);
      end else if (state_q == S_WRITE || state_q == S_READ) begin
        addr_q <= addr_q + STRIDE_A;
        offs_q <= offs_q + STRIDE_D;
        walk_q <= {walk_q[DATA_W-2:0], walk_q[DATA_W-1]};
      end
      if (issue) raddr_hold_q <= addr_q;
    end
  end

  always_comb begin
    pattern = offs_q;
    case (mode_q)
      PAT_INCR: pattern = offs_q;
      PAT_ADDR: pattern = DATA_W'(addr_q);
      PAT_WALK: pattern = walk_q;
      PAT_INV:  pattern = ~offs_q;
      default:  pattern = offs_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Compare pipeline
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) vld_q <= '0;
    else       vld_q <= LAT'({vld_q, issue});
  end

  // NOTE: the expected-value and address stages carry no reset; they are only
  // ever consumed when the matching valid bit is set, and that bit is reset.
  always_ff @(posedge clk) begin
    exp_q <= EXP_BITS'({exp_q, pattern});
    adr_q <= ADR_BITS'({adr_q, addr_q});
  end

  assign cmp_vld  = vld_q[LAT-1];
  assign cmp_exp  = exp_q[LAT-1];
  assign cmp_addr = adr_q[LAT-1];
  assign mismatch = cmp_vld && (dataout != cmp_exp);

  always_comb begin
    err_d = err_q;
    if (mismatch && err_q != ERR_MAX) err_d = err_q + ERR_W'(1);
  end

  // err_q == 0 doubles as "no mismatch yet": saturation never wraps to zero.
  // pass uses err_d so a mismatch on the final compare (last DRAIN cycle)
  // is already included when DONE is entered.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      err_q   <= '0;
      first_q <= '0;
      pass_q  <= 1'b0;
    end else if (accept) begin
      err_q   <= '0;
      first_q <= '0;
      pass_q  <= 1'b0;
    end else begin
      err_q <= err_d;
      if (mismatch && err_q == '0) first_q <= cmp_addr;
      if (state_q == S_DRAIN && state_d == S_DONE) pass_q <= (err_d == '0);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded from state so reset forces them low without a clock.
  // ---------------------------------------------------------------------------
  assign wr             = (state_q == S_WRITE);
  assign waddress       = wr ? addr_q : '0;
  assign datain         = wr ? pattern : '0;
  assign raddress       = issue ? addr_q : raddr_hold_q;
  assign busy           = (state_q == S_WRITE) || (state_q == S_READ) ||
                          (state_q == S_DRAIN);
  assign done           = (state_q == S_DONE);
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = first_q;

endmodule

// File: tb/tb_mem_test_seq.sv
// -----------------------------------------------------------------------------
// tb_mem_test_seq
//
// Two instances run side by side: A with RD_LATENCY=1 / ERR_W=16 and B with
// RD_LATENCY=2 / ERR_W=2. Each has its own behavioural memory whose read path
// can be corrupted (per-word XOR table, global AND mask). Expected results are
// derived from the pattern definitions with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_mem_test_seq;

  localparam int              N    = 8;
  localparam longint unsigned BASE = 0;
  localparam longint unsigned STR  = 8;
  localparam int              LA   = 1;
  localparam int              LB   = 2;
  localparam int              EWA  = 16;
  localparam int              EWB  = 2;
  localparam int              RUN_CYCLES = 28;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        nrst;
  logic        start_a, start_b;
  logic [1:0]  mode;

  logic [63:0] raddress_a, waddress_a, datain_a, dataout_a, first_err_addr_a;
  logic        wr_a, busy_a, done_a, pass_a;
  logic [EWA-1:0] err_count_a;

  logic [63:0] raddress_b, waddress_b, datain_b, dataout_b, first_err_addr_b;
  logic        wr_b, busy_b, done_b, pass_b;
  logic [EWB-1:0] err_count_b;

  mem_test_seq #(
    .DATA_W(64), .ADDR_W(64), .BASE_ADDR(BASE), .NUM_WORDS(N),
    .STRIDE(STR), .RD_LATENCY(LA), .ERR_W(EWA)
  ) u_dut_a (
    .clk(clk), .nrst(nrst), .start(start_a), .mode(mode),
    .raddress(raddress_a), .waddress(waddress_a), .datain(datain_a),
    .wr(wr_a), .dataout(dataout_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .err_count(err_count_a), .first_err_addr(first_err_addr_a)
  );

  mem_test_seq #(
    .DATA_W(64), .ADDR_W(64), .BASE_ADDR(BASE), .NUM_WORDS(N),
    .STRIDE(STR), .RD_LATENCY(LB), .ERR_W(EWB)
  ) u_dut_b (
    .clk(clk), .nrst(nrst), .start(start_b), .mode(mode),
    .raddress(raddress_b), .waddress(waddress_b), .datain(datain_b),
    .wr(wr_b), .dataout(dataout_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .err_count(err_count_b), .first_err_addr(first_err_addr_b)
  );

  // ---------------------------------------------------------------------------
  // Behavioural memories with a corruptible read path
  // ---------------------------------------------------------------------------
  logic [63:0] mem_a [256];
  logic [63:0] mem_b [256];
  logic [63:0] xor_tab [256];
  logic [63:0] and_mask;
  logic [63:0] rd_a, rd_b1, rd_b2;

  function automatic logic [63:0] fetch(input logic [63:0] stored, input logic [63:0] addr);
    return (stored & and_mask) ^ xor_tab[addr[10:3]];
  endfunction

  always @(posedge clk) begin
    if (wr_a) mem_a[waddress_a[10:3]] <= datain_a;
    rd_a <= fetch(mem_a[raddress_a[10:3]], raddress_a);
  end

  always @(posedge clk) begin
    if (wr_b) mem_b[waddress_b[10:3]] <= datain_b;
    rd_b1 <= fetch(mem_b[raddress_b[10:3]], raddress_b);
    rd_b2 <= rd_b1;
  end

  assign dataout_a = rd_a;
  assign dataout_b = rd_b2;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [63:0] word_addr(input int i);
    return BASE + longint'(i) * STR;
  endfunction

  function automatic logic [63:0] pat(input logic [1:0] m, input int i);
    logic [63:0] off;
    off = longint'(i) * STR;
    case (m)
      2'd0:    return off;
      2'd1:    return BASE + off;
      2'd2:    return 64'd1 << (i % 64);
      default: return ~off;
    endcase
  endfunction

  task automatic predict(input logic [1:0] m, output int cnt, output logic [63:0] first);
    logic [63:0] e, got, a;
    cnt   = 0;
    first = '0;
    for (int i = 0; i < N; i++) begin
      e   = pat(m, i);
      a   = word_addr(i);
      got = (e & and_mask) ^ xor_tab[a[10:3]];
      if (got !== e) begin
        if (cnt == 0) first = a;
        cnt++;
      end
    end
  endtask

  function automatic int sat(input int cnt, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (cnt > mx) ? mx : cnt;
  endfunction

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_faults();
    and_mask = '1;
    for (int i = 0; i < 256; i++) xor_tab[i] = '0;
  endtask

  task automatic check_zero(input string w);
    check({w, " A.wr"},       64'(wr_a), 64'd0);
    check({w, " A.busy"},     64'(busy_a), 64'd0);
    check({w, " A.done"},     64'(done_a), 64'd0);
    check({w, " A.pass"},     64'(pass_a), 64'd0);
    check({w, " A.err"},      64'(err_count_a), 64'd0);
    check({w, " A.first"},    first_err_addr_a, 64'd0);
    check({w, " A.waddress"}, waddress_a, 64'd0);
    check({w, " A.datain"},   datain_a, 64'd0);
    check({w, " A.raddress"}, raddress_a, 64'd0);
    check({w, " B.wr"},       64'(wr_b), 64'd0);
    check({w, " B.busy"},     64'(busy_b), 64'd0);
    check({w, " B.done"},     64'(done_b), 64'd0);
    check({w, " B.pass"},     64'(pass_b), 64'd0);
    check({w, " B.err"},      64'(err_count_b), 64'd0);
    check({w, " B.first"},    first_err_addr_b, 64'd0);
  endtask

  // One full run on both instances. extra_rel: cycle (relative to the start
  // cycle) where start is pulsed again on both; done_start_rel: cycle where
  // start is pulsed on A only. -1 disables either.
  task automatic run_pair(input string name, input logic [1:0] m,
                          input int extra_rel, input int done_start_rel);
    logic [63:0] wa_a[$], wd_a[$], ra_a[$], wa_b[$], wd_b[$], ra_b[$];
    int first_wr_a, first_wr_b, dn_a, dn_b, drel_a, drel_b, bb_a, bb_b, cnt;
    logic pd_a, pd_b;
    logic [63:0] first;
    first_wr_a = -1; first_wr_b = -1; dn_a = 0; dn_b = 0;
    drel_a = -1; drel_b = -1; bb_a = 0; bb_b = 0; pd_a = 1'bx; pd_b = 1'bx;
    predict(m, cnt, first);

    @(posedge clk); #1;
    mode = m; start_a = 1'b1; start_b = 1'b1;
    for (int rel = 0; rel < RUN_CYCLES; rel++) begin
      if (rel > 0) begin
        start_a = (rel == extra_rel) || (rel == done_start_rel);
        start_b = (rel == extra_rel);
        mode    = m ^ 2'b01;   // input moves mid-run; the run must not follow
      end
      @(negedge clk);
      if (wr_a) begin
        wa_a.push_back(waddress_a); wd_a.push_back(datain_a);
        if (first_wr_a < 0) first_wr_a = rel;
      end
      if (wr_b) begin
        wa_b.push_back(waddress_b); wd_b.push_back(datain_b);
        if (first_wr_b < 0) first_wr_b = rel;
      end
      if (rel >= N + 1 && rel <= 2 * N) begin
        ra_a.push_back(raddress_a);
        ra_b.push_back(raddress_b);
      end
      if (busy_a !== (rel >= 1 && rel <= 2 * N + LA)) bb_a++;
      if (busy_b !== (rel >= 1 && rel <= 2 * N + LB)) bb_b++;
      if (done_a) begin dn_a++; drel_a = rel; pd_a = pass_a; end
      if (done_b) begin dn_b++; drel_b = rel; pd_b = pass_b; end
      @(posedge clk); #1;
    end
    start_a = 1'b0; start_b = 1'b0;

    check({name, " A.wr_count"}, 64'(wa_a.size()), 64'(N));
    check({name, " B.wr_count"}, 64'(wa_b.size()), 64'(N));
    check({name, " A.wr_first_cycle"}, 64'(first_wr_a), 64'd1);
    check({name, " B.wr_first_cycle"}, 64'(first_wr_b), 64'd1);
    for (int i = 0; i < N && i < wa_a.size(); i++) begin
      check($sformatf("%s A.waddr[%0d]", name, i), wa_a[i], word_addr(i));
      check($sformatf("%s A.datain[%0d]", name, i), wd_a[i], pat(m, i));
    end
    for (int i = 0; i < N && i < wa_b.size(); i++) begin
      check($sformatf("%s B.waddr[%0d]", name, i), wa_b[i], word_addr(i));
      check($sformatf("%s B.datain[%0d]", name, i), wd_b[i], pat(m, i));
    end
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s A.raddr[%0d]", name, i), ra_a[i], word_addr(i));
      check($sformatf("%s B.raddr[%0d]", name, i), ra_b[i], word_addr(i));
    end
    check({name, " A.raddr_hold"}, raddress_a, word_addr(N - 1));
    check({name, " A.done_count"}, 64'(dn_a), 64'd1);
    check({name, " B.done_count"}, 64'(dn_b), 64'd1);
    // Latency counts cycles inclusively: the start cycle through the done cycle.
    check({name, " A.latency"}, 64'(drel_a + 1), 64'(1 + 2 * N + LA + 1));
    check({name, " B.latency"}, 64'(drel_b + 1), 64'(1 + 2 * N + LB + 1));
    check({name, " A.busy_window"}, 64'(bb_a), 64'd0);
    check({name, " B.busy_window"}, 64'(bb_b), 64'd0);
    check({name, " A.pass_at_done"}, 64'(pd_a), 64'(cnt == 0));
    check({name, " B.pass_at_done"}, 64'(pd_b), 64'(cnt == 0));
    check({name, " A.pass"}, 64'(pass_a), 64'(cnt == 0));
    check({name, " B.pass"}, 64'(pass_b), 64'(cnt == 0));
    check({name, " A.err_count"}, 64'(err_count_a), 64'(sat(cnt, EWA)));
    check({name, " B.err_count"}, 64'(err_count_b), 64'(sat(cnt, EWB)));
    check({name, " A.first_err"}, first_err_addr_a, first);
    check({name, " B.first_err"}, first_err_addr_b, first);
  endtask

  task automatic reset_mid_write();
    @(posedge clk); #1;
    mode = 2'd0; start_a = 1'b1; start_b = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;     // now in the 1st WRITE cycle
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);                     // middle of the 4th WRITE cycle
    check("rst_mid A.wr_before", 64'(wr_a), 64'd1);
    check("rst_mid A.waddr_before", waddress_a, word_addr(3));
    nrst = 1'b0;
    #1;
    check_zero("rst_mid");
    @(negedge clk);
    nrst = 1'b1;
    begin
      int bad;
      bad = 0;
      repeat (4) begin
        @(negedge clk);
        if (wr_a || busy_a || done_a || wr_b || busy_b || done_b) bad++;
      end
      check("rst_mid idle_after_release", 64'(bad), 64'd0);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed and randomized sequence
  // ---------------------------------------------------------------------------
  initial begin
    nrst = 1'b0; start_a = 1'b0; start_b = 1'b0; mode = 2'd0;
    clear_faults();
    repeat (2) @(negedge clk);
    check_zero("reset");
    nrst = 1'b1;

    // Clean incrementing run; A also sees start during its DONE cycle.
    run_pair("incr_clean", 2'd0, -1, 2 * N + LA + 1);

    // Abort mid-WRITE, then a normal addr-as-data run with a stray start.
    reset_mid_write();
    run_pair("addr_restart", 2'd1, 3, -1);

    // Word at address 24 corrupted on read.
    clear_faults();
    xor_tab[3] = 64'h0000_0000_dead_beef;
    run_pair("corrupt_24", 2'd0, -1, -1);

    // Bit 5 stuck at zero: only the walking-one word 5 fails.
    clear_faults();
    and_mask = ~64'h20;
    run_pair("stuck_bit5", 2'd2, -1, -1);

    // Every read returns zero: B's 2-bit counter saturates at 3.
    clear_faults();
    and_mask = '0;
    run_pair("all_zero", 2'd3, -1, -1);

    for (int r = 0; r < 8; r++) begin
      logic [1:0] m;
      int kind, sel;
      m    = 2'($urandom_range(0, 3));
      kind = $urandom_range(0, 3);
      clear_faults();
      case (kind)
        1: begin
          sel = $urandom_range(1, 255);
          for (int i = 0; i < N; i++)
            if ((sel >> i) & 1) xor_tab[i] = {$urandom, $urandom} | 64'd1;
        end
        2: and_mask = ~(64'd1 << $urandom_range(0, 63));
        3: and_mask = '0;
        default: ;
      endcase
      run_pair($sformatf("rand%0d", r), m, $urandom_range(1, 16), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
